// File: rtl/draw_sched_pkg.sv
// Shared types and default widths for the draw scheduler and its arbiter.
package draw_sched_pkg;

  localparam int unsigned DefNumClients    = 4;
  localparam int unsigned DefXW            = 9;
  localparam int unsigned DefYW            = 8;
  localparam int unsigned DefColorW        = 3;
  localparam int unsigned DefTimeoutCycles = 1024;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRun     = 2'b01,
    StRelease = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after last_grant, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [$clog2(N)-1:0] winner,
  output logic                 valid
);

  localparam int unsigned IW = $clog2(N);

  int unsigned idx;

  // Walk from farthest to nearest so the nearest requester after last_grant overwrites.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int unsigned off = N; off >= 1; off--) begin
      idx = (32'(last_grant) + off) % N;
      if (req[idx]) begin
        winner = IW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Round-robin owner of the bitmap pixel port for start/done shape drawers.
// Optional watchdog enabled by defining DRAW_TIMEOUT_EN (adds timeout_err port).
module draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS    = DefNumClients,
  parameter int unsigned X_W            = DefXW,
  parameter int unsigned Y_W            = DefYW,
  parameter int unsigned COLOR_W        = DefColorW,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CLIENTS-1:0]           req,
  output logic [NUM_CLIENTS-1:0]           client_start,
  input  logic [NUM_CLIENTS-1:0]           client_done,
  input  logic [NUM_CLIENTS-1:0]           client_draw,
  input  logic [NUM_CLIENTS*X_W-1:0]       client_x,
  input  logic [NUM_CLIENTS*Y_W-1:0]       client_y,
  input  logic [NUM_CLIENTS*COLOR_W-1:0]   client_color,
  output logic                             pix_write,
  output logic [X_W-1:0]                   pix_x,
  output logic [Y_W-1:0]                   pix_y,
  output logic [COLOR_W-1:0]               pix_color,
  output logic                             busy,
  output logic [$clog2(NUM_CLIENTS)-1:0]   grant_id
`ifdef DRAW_TIMEOUT_EN
  ,
  output logic                             timeout_err
`endif
);

  localparam int unsigned GW = $clog2(NUM_CLIENTS);
  localparam logic [NUM_CLIENTS-1:0] StartOne = {{(NUM_CLIENTS-1){1'b0}}, 1'b1};

  state_e          state_q;
  logic [GW-1:0]   last_grant_q;
  logic [GW-1:0]   winner;
  logic            win_valid;
  logic            timeout_hit;

  rr_arbiter #(
    .N(NUM_CLIENTS)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .winner     (winner),
    .valid      (win_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      client_start <= '0;
      grant_id     <= '0;
      last_grant_q <= GW'(NUM_CLIENTS - 1);
    end else if (timeout_hit) begin
      // Hung drawer: reclaim the port and let the next requester go first.
      state_q      <= StIdle;
      client_start <= '0;
      last_grant_q <= grant_id;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            grant_id     <= winner;
            client_start <= StartOne << winner;
            state_q      <= StRun;
          end
        end
        StRun: begin
          if (client_done[grant_id]) begin
            client_start <= '0;
            state_q      <= StRelease;
          end
        end
        StRelease: begin
          if (!client_done[grant_id]) begin
            last_grant_q <= grant_id;
            state_q      <= StIdle;
          end
        end
        default: state_q <= state_e'('x);
      endcase
    end
  end

`ifdef DRAW_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;

  assign timeout_hit = (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Held at zero in IDLE so it starts from zero on entry to RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q == StIdle || timeout_hit) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;

  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    pix_write = 1'b0;
    pix_x     = '0;
    pix_y     = '0;
    pix_color = '0;
    if (state_q == StRun) begin
      pix_write = client_draw[grant_id];
      pix_x     = client_x[grant_id*X_W +: X_W];
      pix_y     = client_y[grant_id*Y_W +: Y_W];
      pix_color = client_color[grant_id*COLOR_W +: COLOR_W];
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: drawer models feed expected pixels, a monitor checks them.
module tb_draw_scheduler;

  localparam int NC = 4;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;
  localparam int TO = 16;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   req, start, done, draw;
  logic [NC*XW-1:0] cx;
  logic [NC*YW-1:0] cy;
  logic [NC*CW-1:0] cc;
  logic            pix_write;
  logic [XW-1:0]   pix_x;
  logic [YW-1:0]   pix_y;
  logic [CW-1:0]   pix_color;
  logic            busy;
  logic [GW-1:0]   grant_id;
`ifdef DRAW_TIMEOUT_EN
  logic            timeout_err;
`endif

  draw_scheduler #(
    .NUM_CLIENTS(NC), .X_W(XW), .Y_W(YW), .COLOR_W(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .client_start (start),
    .client_done  (done),
    .client_draw  (draw),
    .client_x     (cx),
    .client_y     (cy),
    .client_color (cc),
    .pix_write    (pix_write),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_color    (pix_color),
    .busy         (busy),
    .grant_id     (grant_id)
`ifdef DRAW_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
  } pix_t;

  int   tests = 0;
  int   fails = 0;
  pix_t sb[$];
  int   gq[$];
  int   model_last = NC - 1;
  int   wcount = 0;
  int   x300 = 0;
  int   mode = 0;
  logic [NC-1:0] dreq = '0;
  logic [NC-1:0] prev_req = '0, prev_start = '0, prev_done = '0;

  // Behavioural drawer state: 0 idle, 1 drawing, 2 done handshake.
  int            ph[NC], pidx[NC], pw[NC], phh[NC], hold[NC];
  logic [XW-1:0] bx[NC];
  logic [YW-1:0] by[NC];
  logic [CW-1:0] bc[NC];
  bit            fixed[NC], hang[NC], noisy[NC];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(logic [NC-1:0] r, int last);
    for (int k = 1; k <= NC; k++) begin
      if (r[(last + k) % NC]) return (last + k) % NC;
    end
    return -1;
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < NC; i++) if (ph[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_noise(int i, bit on);
    draw[i] = on;
    cx[i*XW +: XW] = XW'(300);
    cy[i*YW +: YW] = YW'($urandom);
    cc[i*CW +: CW] = CW'($urandom);
  endtask

  task automatic emit(int i);
    if (pidx[i] < pw[i] * phh[i]) begin
      if (!fixed[i] && $urandom_range(3) == 0) begin
        draw[i] = 1'b0;
      end else begin
        pix_t p;
        p.x = XW'(int'(bx[i]) + pidx[i] % pw[i]);
        p.y = YW'(int'(by[i]) + pidx[i] / pw[i]);
        p.c = bc[i];
        draw[i] = 1'b1;
        cx[i*XW +: XW] = p.x;
        cy[i*YW +: YW] = p.y;
        cc[i*CW +: CW] = p.c;
        sb.push_back(p);
        pidx[i]++;
      end
    end else begin
      draw[i] = 1'b0;
      if (!hang[i]) begin
        done[i] = 1'b1;
        ph[i]   = 2;
        hold[i] = fixed[i] ? 0 : $urandom_range(2);
      end
    end
  endtask

  task automatic step();
    if (mode == 0) begin
      req = dreq;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (!req[i] && ph[i] == 0 && !start[i] && $urandom_range(3) == 0) req[i] = 1'b1;
        else if (req[i] && start[i] && $urandom_range(2) == 0) req[i] = 1'b0;
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (!reset) begin
        ph[i] = 0; draw[i] = 1'b0; done[i] = 1'b0;
        continue;
      end
      case (ph[i])
        0: begin
          if (start[i]) begin
            if (!fixed[i]) begin
              pw[i]  = $urandom_range(1, 3);
              phh[i] = $urandom_range(1, 3);
              bx[i]  = XW'($urandom_range(0, 250));
              by[i]  = YW'($urandom_range(0, 200));
              bc[i]  = CW'($urandom);
            end
            pidx[i] = 0;
            ph[i]   = 1;
            emit(i);
          end else begin
            set_noise(i, noisy[i] || ($urandom_range(1) == 1));
          end
        end
        1: begin
          if (!start[i]) begin
            ph[i] = 0; draw[i] = 1'b0;
          end else begin
            emit(i);
          end
        end
        default: begin
          if (start[i]) begin
            draw[i] = 1'b0;
          end else if (hold[i] > 0) begin
            hold[i]--;
            set_noise(i, $urandom_range(1) == 1);
          end else begin
            done[i] = 1'b0; draw[i] = 1'b0; ph[i] = 0;
          end
        end
      endcase
    end
    if (!reset) sb.delete();
  endtask

  initial begin
    req = '0; done = '0; draw = '0; cx = '0; cy = '0; cc = '0;
    forever begin
      @(posedge clk);
      #1;
      step();
    end
  end

  task automatic mon();
    if (!reset) begin
      model_last = NC - 1;
      prev_start = '0;
      prev_done  = '0;
      prev_req   = req;
      return;
    end
    if (start != '0 && prev_start == '0) begin
      int e;
      e = rr_pick(prev_req, model_last);
      check("grant_vec", 64'(start), (e < 0) ? 64'd0 : 64'(1) << e);
      check("grant_id", 64'(grant_id), 64'(e));
      if (e >= 0) model_last = e;
      gq.push_back(int'(grant_id));
    end
    check("start_onehot", 64'($countones(start) <= 1), 64'd1);
    if (start != '0) check("busy_run", 64'(busy), 64'd1);
    for (int g = 0; g < NC; g++) begin
      if (prev_start[g] && prev_done[g]) check("start_fall", 64'(start[g]), 64'd0);
      else if (prev_start[g] && !hang[g]) check("start_hold", 64'(start[g]), 64'd1);
    end
    if (pix_write) begin
      wcount++;
      if (pix_x == XW'(300)) x300++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pix_extra: got write (%0d,%0d) expected none", pix_x, pix_y);
      end else begin
        pix_t e;
        e = sb.pop_front();
        check("pixel", 64'({pix_x, pix_y, pix_color}), 64'(e));
      end
    end else if (start == '0) begin
      check("pix_idle_zero", 64'({pix_x, pix_y, pix_color}), 64'd0);
    end
    prev_req   = req;
    prev_start = start;
    prev_done  = done;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon();
    end
  end

  task automatic wait_start(int g, int bound, string name);
    int n = 0;
    while (!start[g] && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 64'(start[g]), 64'd1);
  endtask

  task automatic wait_idle(int bound, string name);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(!busy && start == '0 && req == '0 && done == '0 && all_idle()) && n < bound);
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
  endtask

  task automatic set_fixed(int i, int x, int y, int w, int h);
    fixed[i] = 1'b1;
    bx[i] = XW'(x); by[i] = YW'(y); pw[i] = w; phh[i] = h; bc[i] = CW'(5);
  endtask

  initial begin
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_start", 64'(start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_pix", 64'({pix_write, pix_x, pix_y, pix_color}), 64'd0);
    @(posedge clk);
    #3 reset = 1'b1;

    // Single 2x2 ball at (10,20) with exact latency.
    set_fixed(0, 10, 20, 2, 2);
    wcount = 0;
    @(posedge clk);
    #2 dreq = 4'b0001;
    @(posedge clk);
    #2;
    @(negedge clk);
    #1 check("lat_before", 64'(start), 64'd0);
    @(negedge clk);
    #1 check("lat_start", 64'(start), 64'b0001);
    dreq = '0;
    wait_idle(50, "single_idle");
    check("single_writes", 64'(wcount), 64'd4);
    fixed[0] = 1'b0;

    // Round-robin over eight grants from a fresh reset.
    do_reset();
    gq.delete();
    dreq = 4'b1111;
    for (int n = 0; n < 600 && gq.size() < 8; n++) @(negedge clk);
    dreq = '0;
    wait_idle(100, "rr_idle");
    check("rr_count", 64'(gq.size() >= 8), 64'd1);
    if (gq.size() >= 8) begin
      for (int k = 0; k < 8; k++) check("rr_order", 64'(gq[k]), 64'(k % 4));
    end

    // Isolation: client 2 spams x=300 while client 1 owns the port.
    noisy[2] = 1'b1;
    x300 = 0;
    dreq = 4'b0010;
    wait_start(1, 20, "iso_grant");
    dreq = '0;
    wait_idle(100, "iso_idle");
    check("iso_no300", 64'(x300), 64'd0);
    noisy[2] = 1'b0;

    // Request drops mid-RUN; grant still completes.
    set_fixed(1, 40, 50, 3, 3);
    wcount = 0;
    dreq = 4'b0010;
    wait_start(1, 20, "drop_grant");
    @(posedge clk);
    #2 dreq = '0;
    wait_idle(100, "drop_idle");
    check("drop_writes", 64'(wcount), 64'd9);
    repeat (3) @(negedge clk);
    #1 check("drop_stay_idle", 64'(busy), 64'd0);
    fixed[1] = 1'b0;

    // Reset during pixel 2.
    set_fixed(0, 10, 20, 2, 2);
    wcount = 0;
    dreq = 4'b0001;
    wait_start(0, 20, "rst_grant");
    for (int n = 0; n < 20 && wcount < 1; n++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("rstmid_start", 64'(start), 64'd0);
    check("rstmid_write", 64'(pix_write), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    wait_start(0, 20, "rstmid_regrant");
    check("rstmid_gid", 64'(grant_id), 64'd0);
    dreq = '0;
    wait_idle(50, "rstmid_idle");
    fixed[0] = 1'b0;

    // Randomized traffic.
    mode = 1;
    repeat (3000) @(posedge clk);
    #2 mode = 0;
    dreq = '0;
    wait_idle(300, "rand_idle");

`ifdef DRAW_TIMEOUT_EN
    do_reset();
    #1 check("to_err_clear", 64'(timeout_err), 64'd0);
    set_fixed(3, 5, 5, 1, 1);
    hang[3] = 1'b1;
    dreq = 4'b1000;
    wait_start(3, 20, "to_grant");
    dreq = 4'b0001;
    begin
      int n = 1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        #1;
        if (!start[3]) break;
        n++;
      end
      check("to_run_cycles", 64'(n), 64'(TO));
    end
    check("to_busy", 64'(busy), 64'd0);
    check("to_err_set", 64'(timeout_err), 64'd1);
    wait_start(0, 20, "to_next_grant");
    check("to_next_gid", 64'(grant_id), 64'd0);
    dreq = '0;
    wait_idle(100, "to_idle");
    hang[3] = 1'b0;
    fixed[3] = 1'b0;
    check("to_err_sticky", 64'(timeout_err), 64'd1);
`endif

    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Shares the single bitmap pixel-write port between up to NUM_CLIENTS shape drawers (ball, paddles, score, erase), each using a start/done handshake.
- Grants one requester at a time, round-robin, and pulses that drawer's start.
- Routes the granted drawer's draw/x/y and colour to the pixel port until the drawer reports done and then drops done.
- Sits between the pong game FSM, which raises requests, and the VGA bitmap memory.

Parameters:
- NUM_CLIENTS, 4, number of drawer clients (2..8).
- X_W, 9, pixel x width.
- Y_W, 8, pixel y width.
- COLOR_W, 3, pixel colour width.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with DRAW_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_CLIENTS  request per client; level, held until serviced.
- client_start  out  NUM_CLIENTS  start to each drawer; one-hot or zero.
- client_done  in  NUM_CLIENTS  done from each drawer.
- client_draw  in  NUM_CLIENTS  pixel-valid from each drawer.
- client_x  in  NUM_CLIENTS*X_W  packed x; client i at [i*X_W +: X_W].
- client_y  in  NUM_CLIENTS*Y_W  packed y.
- client_color  in  NUM_CLIENTS*COLOR_W  packed colour.
- pix_write  out  1  pixel write strobe to bitmap.
- pix_x  out  X_W  pixel x.
- pix_y  out  Y_W  pixel y.
- pix_color  out  COLOR_W  pixel colour.
- busy  out  1  grant held (state != IDLE).
- grant_id  out  $clog2(NUM_CLIENTS)  current or last granted client.
- timeout_err  out  1  sticky watchdog flag; present only with DRAW_TIMEOUT_EN.

Behaviour:
- Reset is asynchronous and active-low. While reset is low:
  - state=IDLE; client_start=0; busy=0; grant_id=0.
  - last_grant=NUM_CLIENTS-1, so client 0 has first priority.
  - pix_write=0, pix_x=0, pix_y=0, pix_color=0.
- If reset asserts mid-operation, start drops immediately and the drawer returns to its own reset/start state.
- FSM states, all registered:
  - IDLE: if any req bit is high, the winner is the first requesting index after last_grant, wrapping modulo NUM_CLIENTS. Register grant_id=winner and go to RUN. Otherwise stay in IDLE.
  - RUN: client_start[grant_id]=1. Stay until client_done[grant_id]=1, then go to RELEASE.
  - RELEASE: client_start=0. Stay until client_done[grant_id]=0, then set last_grant=grant_id and go to IDLE.
- Latency:
  - req high in IDLE at edge t gives start high after edge t+1.
  - done seen at edge k gives start low after edge k+1.
  - Minimum IDLE gap between grants: 1 cycle.
- Pixel mux is combinational, from the state and the selected client inputs:
  - pix_write = (state==RUN) & client_draw[grant_id].
  - pix_x, pix_y, pix_color = selected client's fields when state==RUN; otherwise 0.
  - Draw pulses from any non-granted client are ignored.
  - Draw from the granted client outside RUN is ignored.
- busy = (state != IDLE). client_start is one-hot in RUN and zero in every other state.
- Boundary rules:
  - req for the granted client may drop during RUN or RELEASE; the grant still runs to completion.
  - A client whose req stays high after completion is not re-granted while any other client requests (fairness).
  - If it is the sole requester, it is re-granted after the 1-cycle IDLE.
  - done already high in IDLE is ignored.
  - Indices >= NUM_CLIENTS never win arbitration.

Optional Feature:
- Macro DRAW_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to RUN and counts in RUN and RELEASE.
  - On reaching TIMEOUT_CYCLES-1, the FSM forces IDLE, sets last_grant=grant_id and sets timeout_err=1.
  - timeout_err stays high until reset; the hung client is skipped once.
- Not defined: no counter, no timeout_err port, and a hung client holds the port indefinitely.

Decomposition:
- Package draw_sched_pkg holds:
  - the state enum (IDLE, RUN, RELEASE, with 'X default for the unreachable encoding);
  - the width localparams.
- Sub-module rr_arbiter: request vector plus last_grant in; winner index plus valid out; purely combinational, reusable.

Test Plan:
- Single request, NUM_CLIENTS=4: drive req=0001 to a ball drawer at x=10,y=20.
  - start[0] rises 1 cycle later.
  - Pixels written in order: (10,20), (11,20), (10,21), (11,21), with pix_write high for exactly 4 cycles.
  - start falls 1 cycle after done; busy clears after done falls.
- Round-robin: hold req=1111 across 8 grants → grant order 0,1,2,3,0,1,2,3, with no overlapping start bits.
- Isolation: client 2 toggles draw with x=300 while client 1 is granted → pix_x never 300; pix_write follows client 1 only.
- Request drop: req=0010 granted, then req->0000 mid-RUN → grant completes normally, then IDLE with busy=0.
- Reset mid-RUN: drive reset low during pixel 2 → start, pix_write and busy are 0 asynchronously. After release, req=0001 restarts from client 0.
- DRAW_TIMEOUT_EN, TIMEOUT_CYCLES=16: client 3 never asserts done → FSM returns to IDLE after 16 cycles, timeout_err=1, and the next requester (client 0) is granted.
